// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU MMIO sequencer: FSM states, address pages, STATUS bits.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] PAGE_A      = 8'h01;
    localparam logic [7:0] PAGE_B      = 8'h02;
    localparam logic [7:0] PAGE_C      = 8'h03;
    localparam logic [7:0] PAGE_CTRL   = 8'h04;
    localparam logic [7:0] PAGE_STATUS = 8'h05;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERR      = 2;
    localparam int STAT_IRQ_MASK = 3;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic ctrl;
        logic status;
    } page_sel_t;

endpackage

// File: rtl/tpu_addr_dec.sv
// Address decoder: splits an MMIO address into page select, row index and C word index.
module tpu_addr_dec
    import tpu_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    parameter int CW    = 2,
    parameter int RW    = $clog2(DIM),
    parameter int WW    = (CW > 1) ? $clog2(CW) : 1
) (
    input  logic [ADDRW-1:0] addr,
    output page_sel_t        sel,
    output logic [RW-1:0]    row,
    output logic [WW-1:0]    word
);

    localparam int PW = ADDRW - 8;

    logic [PW-1:0] page;
    logic [4:0]    offset;

    assign page   = addr[ADDRW-1:8];
    assign offset = addr[7:3];

    assign sel.a      = (page == PW'(PAGE_A));
    assign sel.b      = (page == PW'(PAGE_B));
    assign sel.c      = (page == PW'(PAGE_C));
    assign sel.ctrl   = (addr == {PW'(PAGE_CTRL), 8'h00});
    assign sel.status = (addr == {PW'(PAGE_STATUS), 8'h00});

    // A C row spans CW consecutive 8-byte words, so the word offset splits into row and word
    assign row  = sel.c ? RW'(int'(offset) / CW) : RW'(offset);
    assign word = WW'(int'(offset) % CW);

endmodule

// File: rtl/tpu_mmio_seq.sv
// MMIO front end and run sequencer for the systolic array.
// Optional feature: define TPU_IRQ_EN to add the irq output and the STATUS irq_mask bit.
module tpu_mmio_seq
    import tpu_pkg::*;
#(
    parameter int DIM     = 8,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    r_w,
    input  logic [ADDRW-1:0]        addr,
    input  logic [DATAW-1:0]        dataIn,
    output logic [DATAW-1:0]        dataOut,
    output logic                    rd_valid,
    output logic                    wr_en_a,
    output logic                    wr_en_b,
    output logic                    wr_en_c,
    output logic [$clog2(DIM)-1:0]  row,
    output logic [DIM*BITS_C-1:0]   wr_data,
    input  logic [DIM*BITS_C-1:0]   c_rdata,
    output logic                    sa_en,
    output logic                    busy
`ifdef TPU_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int CW      = DIM * BITS_C / DATAW;
    localparam int RW      = $clog2(DIM);
    localparam int WW      = (CW > 1) ? $clog2(CW) : 1;
    localparam int RUN_LEN = 3 * DIM - 2;
    localparam int SW      = $clog2(RUN_LEN);

    page_sel_t        sel;
    logic [WW-1:0]    word;
    state_t           state;
    logic [SW-1:0]    step;
    logic             done;
    logic             err;
    logic             mask_bit;
    logic             wr_req;
    logic             rd_req;
    logic             wr_ok;
    logic             start_req;
    logic             status_wr;
    logic             blocked;
    logic             run_last;
    logic [3:0]       status_word;
    logic [DATAW-1:0] rdata;

    tpu_addr_dec #(
        .DIM   (DIM),
        .ADDRW (ADDRW),
        .CW    (CW),
        .RW    (RW),
        .WW    (WW)
    ) u_dec (
        .addr (addr),
        .sel  (sel),
        .row  (row),
        .word (word)
    );

    assign wr_req    = rst_n & req & r_w;
    assign rd_req    = req & ~r_w;
    assign wr_ok     = wr_req & ~busy;
    assign wr_en_a   = wr_ok & sel.a;
    assign wr_en_b   = wr_ok & sel.b;
    assign wr_en_c   = wr_ok & sel.c;
    assign start_req = wr_req & sel.ctrl & dataIn[0];
    assign status_wr = wr_req & sel.status;
    assign blocked   = wr_req & busy & (sel.a | sel.b | sel.c | (sel.ctrl & dataIn[0]));
    assign run_last  = (state == RUN) && (step == SW'(RUN_LEN - 1));

    // C writes merge one DATAW word into the current row; A/B rows fit in the low bits
    always_comb begin
        wr_data = '0;
        if (sel.c) begin
            wr_data = c_rdata;
            wr_data[int'(word)*DATAW +: DATAW] = dataIn;
        end else begin
            wr_data[DIM*BITS_AB-1:0] = dataIn;
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[STAT_BUSY]     = busy;
        status_word[STAT_DONE]     = done;
        status_word[STAT_ERR]      = err;
        status_word[STAT_IRQ_MASK] = mask_bit;
    end

    always_comb begin
        rdata = '0;
        if (sel.c) begin
            rdata = c_rdata[int'(word)*DATAW +: DATAW];
        end else if (sel.status) begin
            rdata = DATAW'(status_word);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
            sa_en <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state <= RUN;
                        step  <= '0;
                        sa_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (run_last) begin
                        state <= DONE;
                        sa_en <= 1'b0;
                    end else begin
                        step <= step + SW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    sa_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Setting wins over a write-1-to-clear landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (run_last) begin
                done <= 1'b1;
            end else if (status_wr && dataIn[STAT_DONE]) begin
                done <= 1'b0;
            end
            if (blocked) begin
                err <= 1'b1;
            end else if (status_wr && dataIn[STAT_ERR]) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            dataOut  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                dataOut <= rdata;
            end
        end
    end

`ifdef TPU_IRQ_EN
    logic irq_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (status_wr) begin
                irq_mask <= dataIn[STAT_IRQ_MASK];
            end
            irq <= done & irq_mask;
        end
    end

    assign mask_bit = irq_mask;
`else
    assign mask_bit = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_mmio_seq.sv
// Self-checking bench for tpu_mmio_seq: directed scenarios plus randomized MMIO traffic
// compared every cycle against a timeline model of the run and a shadow of the C array.
module tb_tpu_mmio_seq;

    localparam int DIM     = 8;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int ADDRW   = 16;
    localparam int DATAW   = 64;
    localparam int CW      = DIM * BITS_C / DATAW;
    localparam int RUN_LEN = 3 * DIM - 2;
    localparam int RW      = $clog2(DIM);
    localparam int CWID    = DIM * BITS_C;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req = 1'b0;
    logic             r_w = 1'b0;
    logic [ADDRW-1:0] addr = '0;
    logic [DATAW-1:0] dataIn = '0;
    logic [DATAW-1:0] dataOut;
    logic             rd_valid, wr_en_a, wr_en_b, wr_en_c, sa_en, busy;
    logic [RW-1:0]    row;
    logic [CWID-1:0]  wr_data, c_rdata;
`ifdef TPU_IRQ_EN
    logic             irq;
`endif

    logic [CWID-1:0] c_mem   [DIM];
    logic [CWID-1:0] exp_mem [DIM];
    int n_checks = 0;
    int n_pass = 0;

    // Model state: position in the current run (-1 when idle) and the STATUS flags
    int          run_t = -1;
    bit          m_done = 0, m_err = 0, m_mask = 0, m_irq = 0;
    bit          exp_rdv = 0;
    logic [63:0] exp_dout = '0;

    tpu_mmio_seq #(
        .DIM(DIM), .BITS_AB(BITS_AB), .BITS_C(BITS_C), .ADDRW(ADDRW), .DATAW(DATAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .rd_valid(rd_valid), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
        .wr_en_c(wr_en_c), .row(row), .wr_data(wr_data), .c_rdata(c_rdata),
        .sa_en(sa_en), .busy(busy)
`ifdef TPU_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // The array's C storage: combinational read on row, written on the strobe
    assign c_rdata = c_mem[row];
    always @(posedge clk) begin
        if (wr_en_c) c_mem[row] = wr_data;
    end

    task automatic check_output(input string name, input logic [CWID-1:0] act,
                                input logic [CWID-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        bit          m_busy, m_sa, is_wr, is_rd, e_a, e_b, e_c, stat_wr, start;
        int          off, m_crow, m_word, next_t;
        logic [7:0]  pg;
        logic [3:0]  st;
        logic [CWID-1:0] exp_wd;
        if (!rst_n) begin
            check_output("rst_busy", busy, 0);
            check_output("rst_sa_en", sa_en, 0);
            check_output("rst_rd_valid", rd_valid, 0);
            check_output("rst_dataOut", dataOut, 0);
            check_output("rst_strobes", {wr_en_a, wr_en_b, wr_en_c}, 0);
`ifdef TPU_IRQ_EN
            check_output("rst_irq", irq, 0);
`endif
            run_t = -1; m_done = 0; m_err = 0; m_mask = 0; m_irq = 0;
            exp_rdv = 0; exp_dout = '0;
        end else begin
            m_busy = (run_t >= 0);
            m_sa   = (run_t >= 0) && (run_t < RUN_LEN);
            is_wr  = req && r_w;
            is_rd  = req && !r_w;
            pg     = addr[15:8];
            off    = int'(addr[7:0]) / 8;
            m_crow = (off / CW) % DIM;
            m_word = off % CW;
            e_a    = is_wr && pg == 8'h01 && !m_busy;
            e_b    = is_wr && pg == 8'h02 && !m_busy;
            e_c    = is_wr && pg == 8'h03 && !m_busy;

            check_output("busy", busy, m_busy);
            check_output("sa_en", sa_en, m_sa);
            check_output("wr_en_a", wr_en_a, e_a);
            check_output("wr_en_b", wr_en_b, e_b);
            check_output("wr_en_c", wr_en_c, e_c);
            check_output("rd_valid", rd_valid, exp_rdv);
            if (exp_rdv) check_output("dataOut", dataOut, exp_dout);
            if (e_a || e_b) check_output("wr_data_ab", wr_data, CWID'(dataIn));
            if (e_a) check_output("row_a", row, off % DIM);
            exp_wd = exp_mem[m_crow];
            exp_wd[m_word*64 +: 64] = dataIn;
            if (e_c) begin
                check_output("wr_data_c", wr_data, exp_wd);
                check_output("row_c", row, m_crow);
            end
`ifdef TPU_IRQ_EN
            check_output("irq", irq, m_irq);
`endif
            st = {m_mask, m_err, m_done, m_busy};
            exp_rdv = is_rd;
            if (is_rd) begin
                if (pg == 8'h03) exp_dout = exp_mem[m_crow][m_word*64 +: 64];
                else if (addr == 16'h0500) exp_dout = 64'(st);
                else exp_dout = '0;
            end
            m_irq = m_done && m_mask;
            if (e_c) exp_mem[m_crow] = exp_wd;
            stat_wr = is_wr && addr == 16'h0500;
            start   = is_wr && addr == 16'h0400 && dataIn[0];
            if (run_t < 0) next_t = start ? 0 : -1;
            else next_t = (run_t + 1 > RUN_LEN) ? -1 : run_t + 1;
            m_done = (m_done && !(stat_wr && dataIn[1])) || (next_t == RUN_LEN);
            m_err  = (m_err && !(stat_wr && dataIn[2])) ||
                     (m_busy && is_wr && (pg == 8'h01 || pg == 8'h02 || pg == 8'h03 || start));
`ifdef TPU_IRQ_EN
            if (stat_wr) m_mask = dataIn[3];
`endif
            run_t = next_t;
        end
    end

    task automatic apply_stimulus(input logic rw, input logic [15:0] a, input logic [63:0] d);
        req = 1'b1; r_w = rw; addr = a; dataIn = d;
        @(posedge clk); #1;
        req = 1'b0; r_w = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [63:0] v);
        apply_stimulus(1'b0, a, '0);
        @(negedge clk);
        check_output("rd_valid_lit", rd_valid, 1);
        v = dataOut;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 100; g++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check_output("wait_idle", busy, 0);
    endtask

    initial begin
        logic [63:0] v;
        int cnt, guard, k, ri;
        for (int i = 0; i < DIM; i++) begin
            c_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            exp_mem[i] = c_mem[i];
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_busy", busy, 0);
        check_output("reset_dataOut", dataOut, 0);
        @(posedge clk); #1;

        // A row write to row 2
        req = 1'b1; r_w = 1'b1; addr = 16'h0110; dataIn = 64'h0807060504030201;
        @(negedge clk);
        check_output("a_strobe", wr_en_a, 1);
        check_output("a_row", row, 2);
        check_output("a_data", wr_data[63:0], 64'h0807060504030201);
        @(posedge clk); #1; req = 1'b0; r_w = 1'b0;
        @(negedge clk);
        check_output("a_strobe_once", wr_en_a, 0);
        @(posedge clk); #1;

        // C read of row 1, upper word
        c_mem[1][127:64] = 64'hDEAD;
        exp_mem[1][127:64] = 64'hDEAD;
        req = 1'b1; r_w = 1'b0; addr = 16'h0318;
        @(negedge clk);
        check_output("c_rd_not_yet", rd_valid, 0);
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        check_output("c_rd_valid", rd_valid, 1);
        check_output("c_rd_data", dataOut, 64'hDEAD);
        @(posedge clk); #1;

        // Run timing
        apply_stimulus(1'b1, 16'h0400, 64'h1);
        @(negedge clk);
        check_output("run_busy", busy, 1);
        cnt = 0; guard = 0;
        while (guard < 100) begin
            if (sa_en) cnt++;
            else if (cnt > 0) break;
            guard++;
            @(negedge clk);
        end
        check_output("sa_en_len", cnt, 22);
        @(posedge clk); #1;
        read_reg(16'h0500, v);
        check_output("status_after_run", v, 64'h2);

        // Start and B write while busy are dropped and flag err
        apply_stimulus(1'b1, 16'h0500, 64'h2);
        apply_stimulus(1'b1, 16'h0400, 64'h1);
        idle(3);
        apply_stimulus(1'b1, 16'h0400, 64'h1);
        req = 1'b1; r_w = 1'b1; addr = 16'h0200; dataIn = 64'h55;
        @(negedge clk);
        check_output("b_dropped", wr_en_b, 0);
        @(posedge clk); #1; req = 1'b0; r_w = 1'b0;
        read_reg(16'h0500, v);
        check_output("status_err_busy", v, 64'h5);
        wait_idle();
        read_reg(16'h0500, v);
        check_output("status_done_err", v, 64'h6);
        apply_stimulus(1'b1, 16'h0500, 64'h4);
        read_reg(16'h0500, v);
        check_output("status_err_clr", v, 64'h2);

        // Reset in the middle of a run
        apply_stimulus(1'b1, 16'h0500, 64'h2);
        apply_stimulus(1'b1, 16'h0400, 64'h1);
        idle(10);
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_sa_en", sa_en, 0);
        check_output("abort_dataOut", dataOut, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        read_reg(16'h0500, v);
        check_output("abort_status", v, 64'h0);
        idle(30);
        read_reg(16'h0500, v);
        check_output("abort_no_done", v, 64'h0);

`ifdef TPU_IRQ_EN
        apply_stimulus(1'b1, 16'h0500, 64'h8);
        apply_stimulus(1'b1, 16'h0400, 64'h1);
        guard = 0;
        @(negedge clk);
        while (!(busy && !sa_en) && guard < 100) begin guard++; @(negedge clk); end
        check_output("irq_before", irq, 0);
        @(negedge clk);
        check_output("irq_rise", irq, 1);
        @(posedge clk); #1;
        apply_stimulus(1'b1, 16'h0500, 64'hA);
        @(posedge clk); #1;
        check_output("irq_drop", irq, 0);
        apply_stimulus(1'b1, 16'h0500, 64'h2);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            k  = $urandom_range(0, 9);
            ri = $urandom_range(0, DIM * CW - 1);
            case (k)
                0: apply_stimulus(1'b1, 16'h0100 | 16'($urandom_range(0, DIM - 1) * 8), {$urandom, $urandom});
                1: apply_stimulus(1'b1, 16'h0200 | 16'($urandom_range(0, DIM - 1) * 8), {$urandom, $urandom});
                2: apply_stimulus(1'b1, 16'h0300 | 16'(ri * 8), {$urandom, $urandom});
                3, 4: apply_stimulus(1'b0, 16'h0300 | 16'(ri * 8), '0);
                5: apply_stimulus(1'b0, 16'h0500, '0);
                6: apply_stimulus(1'b1, 16'h0500, 64'($urandom_range(0, 15)));
                7: apply_stimulus(1'b1, 16'h0400, 64'($urandom_range(0, 1)));
                8: begin
                    case ($urandom_range(0, 5))
                        0: apply_stimulus(1'b0, 16'h0000 | 16'($urandom_range(0, 255)), '0);
                        1: apply_stimulus(1'b0, 16'h0600 | 16'($urandom_range(0, 255)), '0);
                        2: apply_stimulus(1'b0, 16'h0408, '0);
                        3: apply_stimulus(1'b0, 16'h0508, '0);
                        4: apply_stimulus(1'b0, 16'h0100, '0);
                        default: apply_stimulus(1'b0, 16'h0400, '0);
                    endcase
                end
                default: idle($urandom_range(1, 8));
            endcase
        end
        idle(30);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tpu_mmio_seq.md
TPU_MMIO_SEQ -- requirements
Module: tpu_mmio_seq

Interface
REQ-001 SHALL have parameter DIM, default 8, systolic array dimension (power of two, >=2).
REQ-002 SHALL have parameter BITS_AB, default 8, A/B element width.
REQ-003 SHALL have parameter BITS_C, default 16, C element width.
REQ-004 SHALL have parameter ADDRW, default 16, MMIO address width.
REQ-005 SHALL have parameter DATAW, default 64, MMIO data width; DIM*BITS_AB==DATAW and DIM*BITS_C a multiple of DATAW (CW = DIM*BITS_C/DATAW words per C row).
REQ-006 SHALL have ports, with the reset decided as asynchronous, active-low:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  1  MMIO access strobe, one cycle per access
r_w  in  1  0=read, 1=write
addr  in  ADDRW  MMIO address
dataIn  in  DATAW  write data
dataOut  out  DATAW  read data
rd_valid  out  1  dataOut valid
wr_en_a / wr_en_b / wr_en_c  out  1  datapath row-write strobes
row  out  clog2(DIM)  row index for A/C writes and C read
wr_data  out  DIM*BITS_C  C row write data (A/B use low DATAW bits)
c_rdata  in  DIM*BITS_C  C row from array, combinational on row
sa_en  out  1  systolic array/memory advance enable
busy  out  1  computation in progress

Function
REQ-007 Address map SHALL be: 0x01xx A row write (row=addr[3+:log2 DIM], 8-byte stride); 0x02xx B row write, same stride; 0x03xx C read/write (row=addr/(8*CW), word=(addr/8)%CW); 0x0400 CTRL write; 0x0500 STATUS read/write.
REQ-008 Write strobes SHALL assert combinationally in the cycle of req&r_w; A/B strobe with row decoded; C write SHALL read-modify-write one DATAW word of the row into wr_data from c_rdata.
REQ-009 Read SHALL return registered dataOut with rd_valid high exactly one cycle after req&!r_w; unmapped addresses SHALL return 0 with rd_valid.
REQ-010 STATUS bits SHALL be: [0] busy, [1] done, [2] err; writing 1 to bit1 or bit2 SHALL clear that bit.
REQ-011 FSM SHALL have states IDLE, RUN, DONE.
REQ-012 IDLE->RUN on CTRL write with dataIn[0]=1; RUN SHALL last exactly 3*DIM-2 cycles with sa_en=1, driven by a step counter cleared on entry.
REQ-013 RUN->DONE on last step; DONE SHALL set done, hold one cycle, then return to IDLE.
REQ-014 busy SHALL be high in RUN and DONE only.
REQ-015 CTRL start while busy SHALL be ignored and set err.
REQ-016 A/B/C writes while busy SHALL be dropped (no strobe) and set err; reads while busy SHALL proceed.
REQ-017 Simultaneous done-set and done-clear SHALL leave done set.

Reset
REQ-018 On rst_n low: FSM=IDLE, step counter=0, done=err=0, dataOut=0, rd_valid=0, sa_en=0, busy=0, strobes 0.
REQ-019 Reset mid-RUN SHALL abort immediately with no done set after release.

Configuration
REQ-020 Macro TPU_IRQ_EN defined: SHALL add output irq (1 bit) and STATUS bit[3] irq_mask (reset 0); irq = done & irq_mask, registered.
REQ-021 Macro TPU_IRQ_EN undefined: no irq port; STATUS bit[3] reads 0, writes ignored.

Structure
REQ-022 Package tpu_pkg SHALL hold the state enum, address-page constants (0x01..0x05) and STATUS bit positions.
REQ-023 One sub-module tpu_addr_dec SHALL decode addr into page select, row and word index.

Verification
REQ-024 Write 0x0400=1 from IDLE -> busy next cycle, sa_en high exactly 22 cycles (DIM=8), STATUS reads 0x2 after.
REQ-025 Write 0x0110 data 0x0807060504030201 -> wr_en_a one cycle, row=2, wr_data low 64b matches.
REQ-026 Read 0x0318 with c_rdata row1 upper word 0xDEAD -> dataOut=0xDEAD, rd_valid one cycle later.
REQ-027 Start during RUN and write 0x0200 during RUN -> no restart, no wr_en_b, STATUS bit2=1; write 0x0500=0x4 clears it.
REQ-028 Deassert rst_n at RUN step 10 -> all outputs 0, STATUS=0 after release.
REQ-029 TPU_IRQ_EN, mask=1, run matmul -> irq rises one cycle after done; write 0x0500=0x2 drops irq.
